memory_responder: RTL

Memory-side end of the external bus. It answers the bus control strobes: ROM instruction read, RAM data read and RAM data write. It holds a 256x16 instruction ROM and a 256x16 data RAM, inserts a configurable number of wait states, and returns read data with a one-cycle ready pulse. The ROM is filled through a load port driven by the bench or boot logic.

---
 rtl/memory_responder_pkg.sv | 28 ++
 rtl/memory_responder_if.sv | 37 +++
 rtl/memory_responder_mem_array.sv | 27 ++
 rtl/memory_responder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared types and defaults for the memory-side bus responder.
package mem_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned WAIT_MAX   = 7;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ROM_RD = 2'd0,
    OP_RAM_RD = 2'd1,
    OP_RAM_WR = 2'd2
  } op_t;

  // Number of request strobes raised at once; anything above one is illegal.
  function automatic logic [1:0] strobe_count(input logic rom_rd, input logic ram_rd,
                                              input logic ram_wr);
    return 2'(rom_rd) + 2'(ram_rd) + 2'(ram_wr);
  endfunction

endpackage

// File: rtl/memory_responder_if.sv
// External bus between the requester (master) and the memory responder (slave).
interface memory_responder_if
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              i_instr_rom_read;
  logic              i_data_ram_read;
  logic              i_data_ram_write;
  logic [ADDR_W-1:0] i_address_bus;
  logic [DATA_W-1:0] i_data_bus;
  logic              i_load_en;
  logic [ADDR_W-1:0] i_load_addr;
  logic [DATA_W-1:0] i_load_data;
  logic [DATA_W-1:0] o_instr;
  logic [DATA_W-1:0] o_data;
  logic              o_ready;
  logic              o_busy;
  logic              o_err;

  modport master (
    output i_instr_rom_read, i_data_ram_read, i_data_ram_write,
    output i_address_bus, i_data_bus,
    output i_load_en, i_load_addr, i_load_data,
    input  o_instr, o_data, o_ready, o_busy, o_err
  );

  modport slave (
    input  i_instr_rom_read, i_data_ram_read, i_data_ram_write,
    input  i_address_bus, i_data_bus,
    input  i_load_en, i_load_addr, i_load_data,
    output o_instr, o_data, o_ready, o_busy, o_err
  );

endinterface

// File: rtl/memory_responder_mem_array.sv
// Single-port word array: synchronous write, combinational read. Contents are
// not reset; they survive a responder reset.
module mem_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Word write on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_responder.sv
// Memory-side bus responder: instruction ROM read, data RAM read/write with
// configurable wait states, one-cycle ready pulse and illegal-request error.
module memory_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic               i_clk,
  input logic               i_rst_n,
  memory_responder_if.slave bus
);

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [1:0]        n_strobes;
  logic              any_strobe;
  logic              rom_we;
  logic              ram_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rdata;
  logic [DATA_W-1:0] ram_rdata;

  assign n_strobes  = strobe_count(bus.i_instr_rom_read, bus.i_data_ram_read,
                                   bus.i_data_ram_write);
  assign any_strobe = (n_strobes != 2'd0);

  // ROM loading is only accepted while idle with the bus quiet; a reset edge
  // never writes either array.
  assign rom_we   = i_rst_n && (state_q == IDLE) && !any_strobe && bus.i_load_en;
  assign ram_we   = i_rst_n && (state_q == DONE) && (op_q == OP_RAM_WR);
  assign rom_addr = rom_we ? bus.i_load_addr : addr_q;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk   (i_clk),
    .we    (rom_we),
    .addr  (rom_addr),
    .wdata (bus.i_load_data),
    .rdata (rom_rdata)
  );

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Next-state, request latch and registered-output values.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    data_d  = data_q;
    ready_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (n_strobes == 2'd1) begin
          addr_d  = bus.i_address_bus;
          wdata_d = bus.i_data_bus;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          if (bus.i_instr_rom_read) begin
            op_d = OP_ROM_RD;
          end else if (bus.i_data_ram_read) begin
            op_d = OP_RAM_RD;
          end else begin
            op_d = OP_RAM_WR;
          end
          state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
        end else if (n_strobes > 2'd1) begin
          err_d   = 1'b1;
          state_d = HOLD;
        end
      end

      WAIT: begin
        // The live bus is ignored here; only the latched request matters.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
        end
        cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
      end

      DONE: begin
        ready_d = 1'b1;
        if (op_q == OP_ROM_RD) begin
          instr_d = rom_rdata;
        end else if (op_q == OP_RAM_RD) begin
          data_d = ram_rdata;
        end
        state_d = HOLD;
      end

      HOLD: begin
        // Wait for the requester to release so a held strobe is served once.
        if (!any_strobe) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ROM_RD;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_instr = instr_q;
  assign bus.o_data  = data_q;
  assign bus.o_ready = ready_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_err   = err_q;

endmodule
